fifo_ctrl_sync: RTL and testbench

FIFO_CTRL_SYNC -- requirements
Module: fifo_ctrl_sync

---
 rtl/fifo_ctrl_sync.sv | 84 ++++++++
 tb/tb_fifo_ctrl_sync.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_sync.sv
// rtl/fifo_ctrl_sync.sv - synchronous FIFO controller driving an external 1-cycle-latency dual-port RAM
module fifo_ctrl_sync #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 36,
    parameter int AFULL_THRESH  = 252,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  ram_wen_no,
    output logic [DATA_WIDTH-1:0] ram_bwen_no,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_ren_no,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    input  logic [DATA_WIDTH-1:0] ram_q_i
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [ADDR_WIDTH:0] wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
    logic                push_ok, pop_ok, valid_q;

    // Accept decisions use the flags registered at the start of the cycle
    assign push_ok = push_i & ~full_o & ~rst_i;
    assign pop_ok  = pop_i & ~empty_o & ~rst_i;

    assign wptr_nxt  = wptr + (ADDR_WIDTH+1)'(push_ok);
    assign rptr_nxt  = rptr + (ADDR_WIDTH+1)'(pop_ok);
    assign count_nxt = wptr_nxt - rptr_nxt;
    assign count_o   = wptr - rptr;

    assign ram_wen_no  = ~push_ok;
    assign ram_bwen_no = {DATA_WIDTH{~push_ok}};
    assign ram_waddr_o = wptr[ADDR_WIDTH-1:0];
    assign ram_data_o  = din_i;
    assign ram_ren_no  = ~pop_ok;
    assign ram_raddr_o = rptr[ADDR_WIDTH-1:0];

    // A read completing into a reset cycle is dropped along with the contents
    assign dout_o       = ram_q_i;
    assign dout_valid_o = valid_q & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr           <= '0;
            rptr           <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            valid_q        <= 1'b0;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            wptr           <= wptr_nxt;
            rptr           <= rptr_nxt;
            full_o         <= (count_nxt == DEPTH_C);
            empty_o        <= (count_nxt == '0);
            almost_full_o  <= (count_nxt >= AFULL_C);
            almost_empty_o <= (count_nxt <= AEMPTY_C);
            valid_q        <= pop_ok;
            // A new error wins over a simultaneous clear
            overflow_o     <= (push_i & full_o) | (overflow_o & ~clr_err_i);
            underflow_o    <= (pop_i & empty_o) | (underflow_o & ~clr_err_i);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// tb/tb_fifo_ctrl_sync.sv - self-checking bench for fifo_ctrl_sync with a behavioural RAM
module tb_fifo_ctrl_sync;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        push_i, pop_i, clr_err_i;
    logic [35:0] din_i;
    logic [35:0] dout_o;
    logic        dout_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
    logic [8:0]  count_o;
    logic        overflow_o, underflow_o;
    logic        ram_wen_no, ram_ren_no;
    logic [35:0] ram_bwen_no, ram_data_o, ram_q_i;
    logic [7:0]  ram_waddr_o, ram_raddr_o;

    fifo_ctrl_sync dut (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(push_i), .din_i(din_i),
        .pop_i(pop_i), .clr_err_i(clr_err_i), .dout_o(dout_o),
        .dout_valid_o(dout_valid_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
        .ram_wen_no(ram_wen_no), .ram_bwen_no(ram_bwen_no), .ram_waddr_o(ram_waddr_o),
        .ram_data_o(ram_data_o), .ram_ren_no(ram_ren_no), .ram_raddr_o(ram_raddr_o),
        .ram_q_i(ram_q_i)
    );

    always #5 clk_i = ~clk_i;

    logic [35:0] mem [256];
    always @(posedge clk_i) begin
        if (!ram_wen_no) mem[ram_waddr_o] <= ram_data_o;
        if (!ram_ren_no) ram_q_i <= mem[ram_raddr_o];
    end

    int n_chk = 0;
    int n_pass = 0;
    int mcnt = 0;
    logic [8:0] mw = '0, mr = '0;
    logic mov = 1'b0, mun = 1'b0;
    logic [35:0] sb[$];

    typedef struct {
        logic        push;
        logic [35:0] din;
        logic        pop;
        int          exp_count;
        logic        exp_valid;
        logic [35:0] exp_dout;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_state(input logic ev, input logic [35:0] exp_d);
        chk("count_o", 64'(count_o), 64'(mcnt));
        chk("full_o", 64'(full_o), 64'(mcnt == 256));
        chk("empty_o", 64'(empty_o), 64'(mcnt == 0));
        chk("almost_full_o", 64'(almost_full_o), 64'(mcnt >= 252));
        chk("almost_empty_o", 64'(almost_empty_o), 64'(mcnt <= 4));
        chk("overflow_o", 64'(overflow_o), 64'(mov));
        chk("underflow_o", 64'(underflow_o), 64'(mun));
        chk("dout_valid_o", 64'(dout_valid_o), 64'(ev));
        if (ev) chk("dout_o", 64'(dout_o), 64'(exp_d));
    endtask

    task automatic cycle(input logic p, input logic [35:0] d, input logic q, input logic c);
        logic epush, epop;
        logic [35:0] exp_d;
        exp_d = '0;
        push_i = p; din_i = d; pop_i = q; clr_err_i = c;
        #1;
        epush = p && (mcnt != 256);
        epop  = q && (mcnt != 0);
        chk("ram_wen_no", 64'(ram_wen_no), 64'(!epush));
        chk("ram_bwen_no", 64'(ram_bwen_no), epush ? 64'h0 : 64'hF_FFFF_FFFF);
        chk("ram_ren_no", 64'(ram_ren_no), 64'(!epop));
        if (epush) chk("ram_waddr_o", 64'(ram_waddr_o), 64'(mw[7:0]));
        if (epush) chk("ram_data_o", 64'(ram_data_o), 64'(d));
        if (epop)  chk("ram_raddr_o", 64'(ram_raddr_o), 64'(mr[7:0]));
        if (epop) exp_d = sb.pop_front();
        if (epush) sb.push_back(d);
        mov = (p && mcnt == 256) || (mov && !c);
        mun = (q && mcnt == 0) || (mun && !c);
        mw = mw + 9'(epush);
        mr = mr + 9'(epop);
        mcnt = mcnt + int'(epush) - int'(epop);
        @(posedge clk_i); #1;
        check_state(epop, exp_d);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; push_i = 1'b1; pop_i = 1'b1; clr_err_i = 1'b0;
        din_i = 36'(($urandom() << 4) ^ $urandom());
        #1;
        chk("rst_ram_wen_no", 64'(ram_wen_no), 64'h1);
        chk("rst_ram_ren_no", 64'(ram_ren_no), 64'h1);
        chk("rst_ram_bwen_no", 64'(ram_bwen_no), 64'hF_FFFF_FFFF);
        chk("rst_dout_valid_o", 64'(dout_valid_o), 64'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        mcnt = 0; mw = '0; mr = '0; mov = 1'b0; mun = 1'b0;
        sb.delete();
        check_state(1'b0, '0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 36'h1, 1'b0, 1, 1'b0, 36'h0};
        vecs[1] = '{1'b1, 36'h2, 1'b0, 2, 1'b0, 36'h0};
        vecs[2] = '{1'b1, 36'h3, 1'b0, 3, 1'b0, 36'h0};
        vecs[3] = '{1'b0, 36'h0, 1'b1, 2, 1'b1, 36'h1};
        vecs[4] = '{1'b0, 36'h0, 1'b1, 1, 1'b1, 36'h2};
        vecs[5] = '{1'b0, 36'h0, 1'b1, 0, 1'b1, 36'h3};
        vecs[6] = '{1'b0, 36'h0, 1'b0, 0, 1'b0, 36'h0};

        rst_i = 1'b1; push_i = 1'b0; pop_i = 1'b0; clr_err_i = 1'b0; din_i = '0;
        @(posedge clk_i); #1;
        do_reset();

        // Basic push/pop ordering from a fixed table
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].push, vecs[i].din, vecs[i].pop, 1'b0);
            chk("tbl_count", 64'(count_o), 64'(vecs[i].exp_count));
            chk("tbl_valid", 64'(dout_valid_o), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk("tbl_dout", 64'(dout_o), 64'(vecs[i].exp_dout));
        end
        chk("tbl_empty", 64'(empty_o), 64'h1);

        // Fill to full, then overflow
        for (int i = 0; i < 256; i++) cycle(1'b1, 36'(($urandom() << 4) ^ $urandom()), 1'b0, 1'b0);
        chk("full_count", 64'(count_o), 64'd256);
        chk("full_flag", 64'(full_o), 64'h1);
        cycle(1'b1, 36'hDEAD, 1'b0, 1'b0);
        chk("ovf_set", 64'(overflow_o), 64'h1);

        // Push+pop while full: push rejected, pop proceeds
        cycle(1'b1, 36'hBEEF, 1'b1, 1'b0);
        chk("fullpp_count", 64'(count_o), 64'd255);
        chk("fullpp_full", 64'(full_o), 64'h0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 64'(overflow_o), 64'h0);

        // Steady-state at 128 with simultaneous push/pop, pointers wrap
        for (int i = 0; i < 127; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) cycle(1'b1, 36'(($urandom() << 4) ^ $urandom()), 1'b1, 1'b0);
        chk("steady_count", 64'(count_o), 64'd128);

        // Drain, then pop while empty with a push in the same cycle
        for (int i = 0; i < 129; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 36'h5A5, 1'b1, 1'b0);
        chk("udf_count", 64'(count_o), 64'd1);
        chk("udf_set", 64'(underflow_o), 64'h1);
        chk("udf_novalid", 64'(dout_valid_o), 64'h0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("udf_clr_vs_new", 64'(underflow_o), 64'h1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("udf_clr", 64'(underflow_o), 64'h0);

        // Reset right after a pop with count=10
        for (int i = 0; i < 10; i++) cycle(1'b1, 36'(i + 100), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        chk("midrst_count", 64'(count_o), 64'd0);
        chk("midrst_empty", 64'(empty_o), 64'h1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
